// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit for the execute stage.
// Handles MUL, MULH, MULHU, DIV, MOD, DIVU, MODU with one op in flight.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          abandon any in-flight op or pending result
//   in_valid/in_ready, op, src1, src2   request handshake and operands
//   out_valid/out_ready, result          response handshake and result
// Configuration:
//   MULDIV_FAST_MUL_EN  single-cycle multiply for MUL/MULH/MULHU; divide stays iterative.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MOD   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic             res_neg_q, rem_neg_q;
    logic [WIDTH-1:0] a_q, hi_q, lo_q;

    logic             accept, is_mul, is_div, sgn_op, s1_neg, s2_neg, div0, last;
    logic [WIDTH-1:0] s1_mag, s2_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_rem_n, div_quo_n;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, final_res, res_n;
    logic             res_load, div_ge;

    // Request decode and operand magnitudes
    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        accept   = in_valid && in_ready;
        is_mul   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
        is_div   = !is_mul && (op != OP_RSVD);
        sgn_op   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
        s1_neg   = sgn_op && src1[WIDTH-1];
        s2_neg   = sgn_op && src2[WIDTH-1];
        s1_mag   = s1_neg ? -src1 : src1;
        s2_mag   = s2_neg ? -src2 : src2;
        div0     = (src2 == '0);
        last     = (cnt_q == CW'(1));
    end

    // One shift-add / restoring-subtract step on the shared hi:lo register pair
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        // Partial remainder is below twice the divisor, so bit WIDTH is a pure borrow flag
        div_trial = div_shift - {1'b0, a_q};
        div_ge    = !div_trial[WIDTH];
        div_rem_n = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_n = {lo_q[WIDTH-2:0], div_ge};
    end

    // Sign fix-up and op selection for the final iteration
    always_comb begin
        prod_mag = {mul_hi_n, mul_lo_n};
        prod_fix = res_neg_q ? -prod_mag : prod_mag;
        quo_fix  = res_neg_q ? -div_quo_n : div_quo_n;
        rem_fix  = rem_neg_q ? -div_rem_n : div_rem_n;
        unique case (op_q)
            OP_MUL:            final_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   final_res = quo_fix;
            default:           final_res = rem_fix;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] fast_a, fast_b, fast_prod;

    // Sign-extend through a WIDTH+1 operand so one multiplier serves signed and unsigned
    always_comb begin
        fast_a    = (2*WIDTH)'($signed({s1_neg, src1}));
        fast_b    = (2*WIDTH)'($signed({s2_neg, src2}));
        fast_prod = fast_a * fast_b;
    end
`endif

    // Next state; flush overrides everything but reset
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((op == OP_RSVD) || (is_div && div0)) begin
                        state_n = DONE;
                    end else if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                        state_n = DONE;
`else
                        state_n = MUL;
`endif
                    end else begin
                        state_n = DIV;
                    end
                end
            end
            MUL, DIV: if (last) state_n = DONE;
            DONE:     if (out_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // Result register load: early-out ops at accept, iterative ops on the last step
    always_comb begin
        res_load = 1'b0;
        res_n    = result;
        if (accept) begin
            if (op == OP_RSVD) begin
                res_load = 1'b1;
                res_n    = '0;
            end else if (is_div && div0) begin
                res_load = 1'b1;
                res_n    = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : src1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (is_mul) begin
                res_load = 1'b1;
                res_n    = (op == OP_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
            end
`endif
        end else if (((state_q == MUL) || (state_q == DIV)) && last) begin
            res_load = 1'b1;
            res_n    = final_res;
        end
        if (flush) res_load = 1'b0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= (state_n == DONE);
            if (res_load) result <= res_n;
            if (accept && !flush) begin
                op_q      <= op;
                cnt_q     <= CW'(WIDTH);
                res_neg_q <= s1_neg ^ s2_neg;
                rem_neg_q <= s1_neg;
                hi_q      <= '0;
                a_q       <= is_mul ? s1_mag : s2_mag;
                lo_q      <= is_mul ? s2_mag : s1_mag;
            end else if (state_q == MUL) begin
                hi_q  <= mul_hi_n;
                lo_q  <= mul_lo_n;
                cnt_q <= cnt_q - CW'(1);
            end else if (state_q == DIV) begin
                hi_q  <= div_rem_n;
                lo_q  <= div_quo_n;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int FAST_LAT = 1;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] src1, src2, result;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and scramble the inputs right after the accept edge
    task automatic issue(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            step();
            cyc++;
        end
        check({tag, " rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op       = o;
        src1     = a;
        src2     = b;
        step();
        in_valid = 1'b0;
        op       = 3'($urandom);
        src1     = $urandom;
        src2     = $urandom;
    endtask

    // Cycles since accept until out_valid, bounded
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int cyc;
        issue(tag, o, a, b);
        wait_valid(cyc);
        check({tag, " lat"}, 64'(cyc), 64'(lat));
        check({tag, " res"}, 64'(result), 64'(exp));
        check({tag, " busy"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " ovd"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        int bad;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; src1 = '0; src2 = '0;
        repeat (3) step();
        check("rst rdy", 64'(in_ready), 64'd0);
        check("rst ovd", 64'(out_valid), 64'd0);
        check("rst res", 64'(result), 64'd0);
        rst = 1'b0;
        step();
        check("post rst rdy", 64'(in_ready), 64'd1);

        // Multiply
        run_op("mul",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh neg",3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mul sh",  3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT);

        // Divide
        run_op("div",     3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
        run_op("mod",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu",    3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, DIV_LAT);
        run_op("modu",    3'd6, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, DIV_LAT);
        run_op("divu big",3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, DIV_LAT);
        run_op("div nd",  3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run_op("mod nd",  3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);

        // Divide by zero, signed overflow, reserved op
        run_op("div0",    3'd3, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, FAST_LAT);
        run_op("mod0",    3'd4, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, FAST_LAT);
        run_op("divu0",   3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, FAST_LAT);
        run_op("modu0",   3'd6, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, FAST_LAT);
        run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
        run_op("mod ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT);
        run_op("rsvd",    3'd7, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, FAST_LAT);

        // Result held while consumer stalls
        issue("hold", 3'd5, 32'h0000_0007, 32'h0000_0002);
        wait_valid(cyc);
        check("hold lat", 64'(cyc), 64'(DIV_LAT));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!out_valid || result !== 32'h3 || in_ready) bad++;
        end
        check("hold stable", 64'(bad), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold ovd", 64'(out_valid), 64'd0);
        check("hold rdy", 64'(in_ready), 64'd1);

        // Flush on the 5th DIV cycle, with in_valid asserted
        issue("fl", 3'd3, 32'd100, 32'd7);
        repeat (4) step();
        flush = 1'b1; in_valid = 1'b1; op = 3'd7;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl rdy", 64'(in_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) bad++;
            step();
        end
        check("fl no ovd", 64'(bad), 64'd0);
        run_op("fl mul",  3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT);

        // Flush beats accept
        in_valid = 1'b1; op = 3'd7; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid || !in_ready) bad++;
            step();
        end
        check("flacc", 64'(bad), 64'd0);

        // Flush beats result hand-off; result is left as is
        issue("flout", 3'd6, 32'd7, 32'd2);
        wait_valid(cyc);
        check("flout lat", 64'(cyc), 64'(DIV_LAT));
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        check("flout ovd", 64'(out_valid), 64'd0);
        check("flout res", 64'(result), 64'd1);
        check("flout rdy", 64'(in_ready), 64'd1);

        // Reset mid-op
        issue("rstop", 3'd3, 32'd100, 32'd7);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("rstop rdy", 64'(in_ready), 64'd0);
        check("rstop ovd", 64'(out_valid), 64'd0);
        check("rstop res", 64'(result), 64'd0);
        rst = 1'b0;
        step();
        check("rstop rdy2", 64'(in_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) bad++;
            step();
        end
        check("rstop no ovd", 64'(bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
